// File: rtl/itlb_walker_if.sv
// itlb_walker_if: iTLB-miss, memory-port, fill and fault signals of the walker.
// master = walker side, slave = iTLB / arbiter / exception-logic side.
interface itlb_walker_if #(
    parameter int unsigned VA_WIDTH  = 20,
    parameter int unsigned PA_WIDTH  = 20,
    parameter int unsigned PTE_WIDTH = 32
);
    logic                 tlb_miss;
    logic [VA_WIDTH-1:0]  miss_vaddr;
    logic [PA_WIDTH-1:0]  ptbr;
    logic                 mem_req;
    logic [PA_WIDTH-1:0]  mem_addr;
    logic                 mem_ack;
    logic [PTE_WIDTH-1:0] mem_rdata;
    logic                 tlb_write;
    logic [PA_WIDTH-1:0]  physical_page_num_mem;
    logic                 stall;
    logic                 page_fault;
    logic [VA_WIDTH-1:0]  fault_vaddr;
    logic                 fault_clr;

    modport master (
        input  tlb_miss, miss_vaddr, ptbr, mem_ack, mem_rdata, fault_clr,
        output mem_req, mem_addr, tlb_write, physical_page_num_mem,
               stall, page_fault, fault_vaddr
    );

    modport slave (
        output tlb_miss, miss_vaddr, ptbr, mem_ack, mem_rdata, fault_clr,
        input  mem_req, mem_addr, tlb_write, physical_page_num_mem,
               stall, page_fault, fault_vaddr
    );
endinterface

// File: rtl/itlb_walker.sv
// itlb_walker: hardware page-table walker servicing iTLB misses.
// Reads one PTE per miss over a req/ack port, fills the iTLB on a valid PTE,
// raises a page fault on an invalid one.
// Optional macro ITLB_WALK_TIMEOUT_EN: faults a walk whose REQ phase lasts
// TIMEOUT_CYCLES without mem_ack.
module itlb_walker #(
    parameter int unsigned VA_WIDTH       = 20,
    parameter int unsigned PA_WIDTH       = 20,
    parameter int unsigned OFFSET_BITS    = 12,
    parameter int unsigned PTE_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          reset,
    itlb_walker_if.master bus
);
    localparam int unsigned VPN_W = VA_WIDTH - OFFSET_BITS;
    localparam int unsigned PPN_W = PA_WIDTH - OFFSET_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_FILL,
        S_DONE,
        S_FAULT
    } state_t;

    state_t              r_state;
    logic [VPN_W-1:0]    r_vpn;
    logic                r_mem_req;
    logic [PA_WIDTH-1:0] r_mem_addr;
    logic                r_tlb_write;
    logic [PA_WIDTH-1:0] r_ppn;
    logic                r_page_fault;
    logic [VA_WIDTH-1:0] r_fault_vaddr;

    logic [VPN_W-1:0]    w_miss_vpn;
    logic [PA_WIDTH-1:0] w_pte_addr;
    logic                w_pte_valid;
    logic [PA_WIDTH-1:0] w_pte_ppn;
    logic [VA_WIDTH-1:0] w_fault_va;
    logic                w_unused_rdata;

    assign w_miss_vpn     = bus.miss_vaddr[VA_WIDTH-1:OFFSET_BITS];
    // PTE address wraps silently at PA_WIDTH.
    assign w_pte_addr     = bus.ptbr + PA_WIDTH'({w_miss_vpn, 2'b00});
    assign w_pte_valid    = bus.mem_rdata[PTE_WIDTH-1];
    assign w_pte_ppn      = PA_WIDTH'(bus.mem_rdata[PPN_W-1:0]);
    assign w_fault_va     = {r_vpn, {OFFSET_BITS{1'b0}}};
    assign w_unused_rdata = ^bus.mem_rdata[PTE_WIDTH-2:PPN_W];

`ifdef ITLB_WALK_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;
    logic [8:0] w_tmo_next;
    logic       w_tmo_hit;

    assign w_tmo_next = {1'b0, r_tmo_cnt} + 9'd1;
    assign w_tmo_hit  = (32'(w_tmo_next) >= TIMEOUT_CYCLES);

    // Count unacknowledged REQ cycles; saturates, clears whenever not waiting in REQ.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_REQ && !bus.mem_ack && !w_tmo_hit) begin
            r_tmo_cnt <= (r_tmo_cnt == 8'hFF) ? r_tmo_cnt : w_tmo_next[7:0];
        end else begin
            r_tmo_cnt <= '0;
        end
    end
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // Walk FSM with registered memory, fill and fault outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_vpn         <= '0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_tlb_write   <= 1'b0;
            r_ppn         <= '0;
            r_page_fault  <= 1'b0;
            r_fault_vaddr <= '0;
        end else begin
            r_tlb_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.tlb_miss) begin
                        r_vpn      <= w_miss_vpn;
                        r_mem_addr <= w_pte_addr;
                        r_mem_req  <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (w_pte_valid) begin
                            r_ppn       <= w_pte_ppn;
                            r_tlb_write <= 1'b1;
                            r_state     <= S_FILL;
                        end else begin
                            r_fault_vaddr <= w_fault_va;
                            r_page_fault  <= 1'b1;
                            r_state       <= S_FAULT;
                        end
                    end
`ifdef ITLB_WALK_TIMEOUT_EN
                    else if (w_tmo_hit) begin
                        r_mem_req     <= 1'b0;
                        r_fault_vaddr <= w_fault_va;
                        r_page_fault  <= 1'b1;
                        r_state       <= S_FAULT;
                    end
`endif
                end
                S_FILL: begin
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                S_FAULT: begin
                    if (bus.fault_clr) begin
                        r_page_fault <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stall is combinational on the miss so fetch freezes in the miss cycle itself.
    assign bus.stall = (r_state == S_REQ) || (r_state == S_FILL) || (r_state == S_FAULT) ||
                       ((r_state == S_IDLE) && bus.tlb_miss);

    assign bus.mem_req               = r_mem_req;
    assign bus.mem_addr              = r_mem_addr;
    assign bus.tlb_write             = r_tlb_write;
    assign bus.physical_page_num_mem = r_ppn;
    assign bus.page_fault            = r_page_fault;
    assign bus.fault_vaddr           = r_fault_vaddr;
endmodule

// File: doc/itlb_walker.md
# itlb_walker

Hardware page-table walker that services iTLB misses in the monocycle core. On a miss it stalls fetch, computes the page-table entry (PTE) address from the page-table base register and the missing virtual page number, and reads the PTE over a req/ack memory port. A valid PTE is written into the iTLB through its fill port (`tlb_write`, `physical_page_num_mem`); an invalid PTE raises a page fault. The block sits between the iTLB, the fetch stall logic and the memory arbiter.

## Interface
- `VA_WIDTH`, 20: virtual address width.
- `PA_WIDTH`, 20: physical address width.
- `OFFSET_BITS`, 12: page offset width; VPN = `VA_WIDTH-OFFSET_BITS`, PPN = `PA_WIDTH-OFFSET_BITS`.
- `PTE_WIDTH`, 32: PTE width; bit `PTE_WIDTH-1` is valid, bits `[PPN-1:0]` are the PPN.
- `TIMEOUT_CYCLES`, 255: maximum REQ cycles before a fault; used only with the timeout feature.

- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `tlb_miss` in 1: iTLB miss for `miss_vaddr`.
- `miss_vaddr` in VA_WIDTH: faulting fetch address.
- `ptbr` in PA_WIDTH: page-table base, word aligned.
- `mem_req` out 1: PTE read request.
- `mem_addr` out PA_WIDTH: PTE address.
- `mem_ack` in 1: read complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in PTE_WIDTH: PTE data.
- `tlb_write` out 1: iTLB fill strobe.
- `physical_page_num_mem` out PA_WIDTH: fill data; the PPN is zero-extended to PA_WIDTH.
- `stall` out 1: freezes fetch.
- `page_fault` out 1: fault pending.
- `fault_vaddr` out VA_WIDTH: address that faulted.
- `fault_clr` in 1: exception logic acknowledges the fault.

## Operation
- FSM states: IDLE, REQ, FILL, DONE, FAULT.
- IDLE → REQ when `tlb_miss`=1.
  - Latch `vpn` = `miss_vaddr[VA_WIDTH-1:OFFSET_BITS]`.
  - `mem_addr` = `ptbr + {vpn,2'b00}`, truncated to PA_WIDTH; wrap-around is silent. This value is registered.
- REQ:
  - `mem_req`=1 and `mem_addr` are held stable until `mem_ack`.
  - On `mem_ack` with PTE valid=1: latch the PPN and go to FILL.
  - On `mem_ack` with valid=0: latch `fault_vaddr` = `{vpn, OFFSET_BITS'b0}` and go to FAULT.
- FILL: `tlb_write`=1 for exactly one cycle, with `physical_page_num_mem` driven. Go to DONE.
- DONE: one cycle; `tlb_miss` is ignored (the iTLB lookup settles). Go to IDLE.
- FAULT: `page_fault`=1 and `stall`=1, held until `fault_clr`=1, then go to IDLE.
- `stall` = (state ∈ {REQ, FILL, FAULT}) OR (state==IDLE AND `tlb_miss`). It is low in DONE.
- `mem_ack` is ignored when `mem_req`=0.
- A `tlb_miss` change during REQ, FILL or FAULT has no effect; the latched VPN is used.
- Reset asserted at any time forces IDLE and clears all outputs immediately; an in-flight request is abandoned.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=0, `tlb_write`=0, `physical_page_num_mem`=0, `stall`=0, `page_fault`=0, `fault_vaddr`=0.
- Miss at edge N → `mem_req`=1 from N+1.
- `mem_ack` at edge M → `tlb_write`=1 during M+1 → DONE at M+2 → IDLE at M+3.
- Minimum miss-to-fill latency (`mem_ack` in the first REQ cycle): 2 cycles.
- `fault_clr` sampled at edge K → IDLE at K+1.
- `fault_clr` outside FAULT is ignored.

## Configuration
- `ITLB_WALK_TIMEOUT_EN` defined:
  - An 8-bit saturating counter runs in REQ.
  - Reaching `TIMEOUT_CYCLES` without `mem_ack` → FAULT, with `fault_vaddr` latched and `mem_req` dropped.
  - If `mem_ack` arrives in the same cycle the count hits the limit, the ack wins.
  - The counter clears on leaving REQ.
- Not defined: no counter; REQ waits indefinitely for `mem_ack`.

## Test plan
- Valid fill: `ptbr`=0x04000, `miss_vaddr`=0x03ABC, `mem_ack`=1 with `mem_rdata`=0x80000055 on the 3rd REQ cycle.
  - `mem_addr`=0x0400C.
  - `tlb_write` for 1 cycle with `physical_page_num_mem`=0x00055.
  - `stall` drops in DONE.
- Invalid PTE: `mem_rdata`=0x00000055.
  - `page_fault`=1 and `fault_vaddr`=0x03000, held for 10 cycles.
  - `fault_clr` → IDLE next cycle; no `tlb_write` occurs.
- Address wrap: `ptbr`=0xFFFFC, `miss_vaddr`=0x02000 → `mem_addr`=0x00004.
- Reset mid-REQ: drive `reset`=0 during REQ → `mem_req`, `stall` = 0 without waiting for a clock edge; a later `mem_ack` produces no `tlb_write`.
- Back-to-back misses: `tlb_miss` held high through DONE → exactly one walk; a new miss in the IDLE after DONE starts a second walk.
- With `ITLB_WALK_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8: no `mem_ack` → `page_fault` after 8 REQ cycles and `mem_req`=0; without the macro, `mem_req` is still 1 after 300 cycles.
